// File: rtl/ir_fusion_pkg.sv
// Shared types and helpers for the IR heading-fusion pipeline.
//   ir_fsm_t       : window FSM states (ACCUM collects samples, COMPUTE forms the correction)
//   NOM_IR_DEFAULT : IR reading seen when the robot is centred
//   sat_add        : clamps a sign-extended sum into a w-bit signed range and flags clamping
package ir_fusion_pkg;

  typedef enum logic [0:0] {
    ACCUM   = 1'b0,
    COMPUTE = 1'b1
  } ir_fsm_t;

  localparam logic [11:0] NOM_IR_DEFAULT = 12'h970;

  typedef struct packed {
    logic               sat;
    logic signed [31:0] val;
  } sat_res_t;

  // The caller passes its W+1-bit sum sign-extended to 32 bits. The result
  // always fits in w signed bits, so the caller may truncate val to w bits.
  function automatic sat_res_t sat_add(input logic signed [31:0] sum, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sat_res_t r;
    hi    = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo    = -(32'sd1 <<< (w - 1));
    r.sat = 1'b0;
    r.val = sum;
    if (sum > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end else if (sum < lo) begin
      r.val = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ir_window_avg.sv
// One side of the IR averaging window: sample accumulator plus sticky open flag.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : end of window; drop the sum (and take a coincident sample as the first of the next window)
//   load       : a new sample is present this cycle
//   sample     : unsigned IR reading
//   opn        : side-open flag for this sample
//   acc        : running sum of the window (W+AVG_LOG2 bits, cannot overflow)
//   opn_sticky : OR of all open flags seen in the window
module ir_window_avg
  import ir_fusion_pkg::*;
#(
  parameter int W        = 12,
  parameter int AVG_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [W-1:0]          sample,
  input  logic                  opn,
  output logic [W+AVG_LOG2-1:0] acc,
  output logic                  opn_sticky
);

  localparam int AW = W + AVG_LOG2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      opn_sticky <= 1'b0;
    end else if (clr) begin
      // A sample arriving on the clearing cycle starts the next window.
      acc        <= load ? AW'(sample) : '0;
      opn_sticky <= load & opn;
    end else if (load) begin
      acc        <= acc + AW'(sample);
      opn_sticky <= opn_sticky | opn;
    end
  end

endmodule

// File: rtl/ir_fusion_pipe.sv
// Sequential IR heading fusion: averages left/right IR over 2^AVG_LOG2 samples,
// derives a centring error, forms a P+D correction and adds it (saturating)
// to the desired heading.
//   clk, rst          : clock, asynchronous active-high reset
//   IR_vld            : one-cycle strobe for a new sample pair
//   lft_IR, rght_IR   : unsigned IR readings
//   lft_opn, rght_opn : side-open flags (sticky over the window)
//   en_fusion         : apply the correction when high, else pass heading through
//   dsrd_hdng         : desired heading (signed)
//   dsrd_hdng_adj     : registered adjusted heading (signed)
//   adj_vld           : one-cycle pulse when dsrd_hdng_adj first carries a new correction
//   sat               : registered with dsrd_hdng_adj, high when the sum was clamped
//   dbg_state, dbg_cnt: window FSM state and sample count
// Handshake: IR_vld is a pure strobe with no back-pressure; every strobe is
// taken, including one landing in COMPUTE (it opens the next window).
module ir_fusion_pipe
  import ir_fusion_pkg::*;
#(
  parameter int             W        = 12,
  parameter logic [W-1:0]   NOM_IR   = W'(NOM_IR_DEFAULT),
  parameter int             AVG_LOG2 = 2,
  parameter int             P_SHFT   = 5,
  parameter int             D_SHFT   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                IR_vld,
  input  logic [W-1:0]        lft_IR,
  input  logic [W-1:0]        rght_IR,
  input  logic                lft_opn,
  input  logic                rght_opn,
  input  logic                en_fusion,
  input  logic signed [W-1:0] dsrd_hdng,
  output logic signed [W-1:0] dsrd_hdng_adj,
  output logic                adj_vld,
  output logic                sat,
  output ir_fsm_t             dbg_state,
  output logic [AVG_LOG2-1:0] dbg_cnt
);

  localparam int AW = W + AVG_LOG2;

  ir_fsm_t             state;
  logic [AVG_LOG2-1:0] cnt;
  logic                in_compute;
  logic [AW-1:0]       lft_acc, rght_acc;
  logic                lft_opn_s, rght_opn_s;

  assign in_compute = (state == COMPUTE);
  assign dbg_state  = state;
  assign dbg_cnt    = cnt;

  ir_window_avg #(.W(W), .AVG_LOG2(AVG_LOG2)) u_lft (
    .clk(clk), .rst(rst), .clr(in_compute), .load(IR_vld),
    .sample(lft_IR), .opn(lft_opn), .acc(lft_acc), .opn_sticky(lft_opn_s)
  );

  ir_window_avg #(.W(W), .AVG_LOG2(AVG_LOG2)) u_rght (
    .clk(clk), .rst(rst), .clr(in_compute), .load(IR_vld),
    .sample(rght_IR), .opn(rght_opn), .acc(rght_acc), .opn_sticky(rght_opn_s)
  );

  // Window FSM. cnt wraps to 0 on the last sample of a window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      cnt   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (IR_vld) begin
            cnt <= cnt + AVG_LOG2'(1);
            if (&cnt) state <= COMPUTE;
          end
        end
        COMPUTE: begin
          cnt   <= IR_vld ? AVG_LOG2'(1) : '0;
          state <= ACCUM;
        end
        default: begin
          state <= ACCUM;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Error and P+D correction, evaluated from the completed window sums.
  logic [W-1:0]        lft_avg, rght_avg;
  logic signed [W:0]   lft_ext, rght_ext, nom_ext, diff, err, p_term, err_prev;
  logic signed [W+1:0] err_x, prev_x, d_diff, d_term, p_x, corr_sum, corr_nxt, corr;

  always_comb begin
    lft_avg  = W'(lft_acc >> AVG_LOG2);
    rght_avg = W'(rght_acc >> AVG_LOG2);
    lft_ext  = {1'b0, lft_avg};
    rght_ext = {1'b0, rght_avg};
    nom_ext  = {1'b0, NOM_IR};
    diff     = lft_ext - rght_ext;
    case ({lft_opn_s, rght_opn_s})
      2'b11:   err = '0;
      2'b10:   err = nom_ext - rght_ext;
      2'b01:   err = lft_ext - nom_ext;
      default: err = diff >>> 1;
    endcase
    p_term   = err >>> P_SHFT;
    err_x    = {err[W], err};
    prev_x   = {err_prev[W], err_prev};
    d_diff   = err_x - prev_x;
    d_term   = d_diff >>> D_SHFT;
    p_x      = {p_term[W], p_term};
    corr_sum = p_x + d_term;
    corr_nxt = corr_sum >>> 1;
  end

  logic corr_upd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr     <= '0;
      err_prev <= '0;
      corr_upd <= 1'b0;
    end else begin
      corr_upd <= in_compute;
      if (in_compute) begin
        corr     <= corr_nxt;
        err_prev <= (lft_opn_s & rght_opn_s) ? '0 : err;
      end
    end
  end

  // Output stage: heading plus correction, clamped to W bits.
  logic signed [31:0] sum32;
  sat_res_t           sres;

  always_comb begin
    sum32 = 32'(dsrd_hdng) + 32'(corr);
    sres  = sat_add(sum32, W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsrd_hdng_adj <= '0;
      sat           <= 1'b0;
      adj_vld       <= 1'b0;
    end else begin
      adj_vld <= corr_upd & en_fusion;
      if (en_fusion) begin
        dsrd_hdng_adj <= W'(sres.val);
        sat           <= sres.sat;
      end else begin
        dsrd_hdng_adj <= dsrd_hdng;
        sat           <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ir_fusion_pipe.sv
module tb_ir_fusion_pipe;
  import ir_fusion_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               IR_vld;
  logic [11:0]        lft_IR, rght_IR;
  logic               lft_opn, rght_opn, en_fusion;
  logic signed [11:0] dsrd_hdng;
  logic signed [11:0] dsrd_hdng_adj;
  logic               adj_vld, sat;
  ir_fsm_t            dbg_state;
  logic [1:0]         dbg_cnt;

  ir_fusion_pipe dut (
    .clk(clk), .rst(rst), .IR_vld(IR_vld), .lft_IR(lft_IR), .rght_IR(rght_IR),
    .lft_opn(lft_opn), .rght_opn(rght_opn), .en_fusion(en_fusion),
    .dsrd_hdng(dsrd_hdng), .dsrd_hdng_adj(dsrd_hdng_adj), .adj_vld(adj_vld),
    .sat(sat), .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Window bookkeeping in plain integers: samples are summed until four are
  // seen; the correction appears one edge later, the heading one edge after that.
  localparam int NOM = 2416;
  int m_lsum, m_rsum, m_n;
  bit m_lo, m_ro;
  bit m_done;
  int m_wl, m_wr;
  bit m_wlo, m_wro;
  int m_corr, m_prev;
  bit m_upd;

  logic [14:0] exp_q[$];  // {in_compute, sat, adj_vld, adj[11:0]}

  task automatic model_reset();
    m_lsum = 0; m_rsum = 0; m_n = 0; m_lo = 0; m_ro = 0;
    m_done = 0; m_wl = 0; m_wr = 0; m_wlo = 0; m_wro = 0;
    m_corr = 0; m_prev = 0; m_upd = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    int sum, lavg, ravg, err, p, d;
    bit e_sat, e_vld;
    e_sat = 0;
    if (en_fusion) begin
      sum = dsrd_hdng;
      sum = sum + m_corr;
      if (sum > 2047) begin sum = 2047; e_sat = 1; end
      else if (sum < -2048) begin sum = -2048; e_sat = 1; end
    end else begin
      sum = dsrd_hdng;
    end
    e_vld = m_upd && en_fusion;
    m_upd = 0;
    if (m_done) begin
      lavg = m_wl / 4;
      ravg = m_wr / 4;
      if (m_wlo && m_wro) err = 0;
      else if (m_wlo)     err = NOM - ravg;
      else if (m_wro)     err = lavg - NOM;
      else                err = (lavg - ravg) >>> 1;
      p = err >>> 5;
      d = (err - m_prev) >>> 2;
      m_corr = (p + d) >>> 1;
      m_prev = (m_wlo && m_wro) ? 0 : err;
      m_upd  = 1;
      m_done = 0;
    end
    if (IR_vld) begin
      m_lsum += lft_IR;
      m_rsum += rght_IR;
      m_lo = m_lo | lft_opn;
      m_ro = m_ro | rght_opn;
      m_n++;
      if (m_n == 4) begin
        m_wl = m_lsum; m_wr = m_rsum; m_wlo = m_lo; m_wro = m_ro;
        m_done = 1;
        m_lsum = 0; m_rsum = 0; m_lo = 0; m_ro = 0; m_n = 0;
      end
    end
    exp_q.push_back({m_done, e_sat, e_vld, 12'(sum)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [14:0] e;
    @(posedge clk);
    model_edge();
    #1;
    e = exp_q.pop_front();
    check("adj",     32'($unsigned(dsrd_hdng_adj)), 32'(e[11:0]));
    check("adj_vld", 32'(adj_vld), 32'(e[12]));
    check("sat",     32'(sat), 32'(e[13]));
    check("state",   32'(dbg_state), 32'(e[14]));
  endtask

  task automatic do_reset();
    IR_vld = 0; lft_opn = 0; rght_opn = 0;
    rst = 1;
    #2;
    check("rst_adj",   32'($unsigned(dsrd_hdng_adj)), 32'd0);
    check("rst_vld",   32'(adj_vld), 32'd0);
    check("rst_sat",   32'(sat), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ACCUM));
    check("rst_cnt",   32'(dbg_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  // Four back-to-back samples, then two idle edges: result is then visible.
  task automatic window(input logic [11:0] l, input logic [11:0] r,
                        input logic [3:0] lo, input logic [3:0] ro);
    for (int i = 0; i < 4; i++) begin
      IR_vld = 1; lft_IR = l; rght_IR = r; lft_opn = lo[i]; rght_opn = ro[i];
      tick();
    end
    IR_vld = 0; lft_opn = 0; rght_opn = 0;
    tick();
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; IR_vld = 0; lft_IR = 0; rght_IR = 0; lft_opn = 0; rght_opn = 0;
    en_fusion = 1; dsrd_hdng = 12'h100;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;

    // Reset mid-window, then two closed windows
    for (int i = 0; i < 2; i++) begin
      IR_vld = 1; lft_IR = 12'hA70; rght_IR = 12'h970; tick();
    end
    do_reset();
    window(12'hA70, 12'h970, 4'b0000, 4'b0000);
    check("w1_adj", 32'($unsigned(dsrd_hdng_adj)), 32'h112);
    check("w1_vld", 32'(adj_vld), 32'd1);
    window(12'hA70, 12'h970, 4'b0000, 4'b0000);
    check("w2_adj", 32'($unsigned(dsrd_hdng_adj)), 32'h102);

    // Both open, then a closed window starting from a zero previous error
    do_reset();
    window(12'h123, 12'h456, 4'b1111, 4'b1111);
    check("open_adj", 32'($unsigned(dsrd_hdng_adj)), 32'h100);
    window(12'hA70, 12'h970, 4'b0000, 4'b0000);
    check("after_open", 32'($unsigned(dsrd_hdng_adj)), 32'h112);

    // Right open on a single sample
    do_reset();
    window(12'h9F0, 12'h123, 4'b0000, 4'b0010);
    check("ropen_adj", 32'($unsigned(dsrd_hdng_adj)), 32'h112);

    // Saturation, positive and negative
    do_reset();
    dsrd_hdng = 12'h7F0;
    window(12'hA70, 12'h970, 4'b0000, 4'b0000);
    check("satp_adj", 32'($unsigned(dsrd_hdng_adj)), 32'h7FF);
    check("satp_sat", 32'(sat), 32'd1);
    do_reset();
    dsrd_hdng = 12'h800;
    window(12'h970, 12'hA70, 4'b0000, 4'b0000);
    check("satn_adj", 32'($unsigned(dsrd_hdng_adj)), 32'h800);
    check("satn_sat", 32'(sat), 32'd1);

    // Fusion disabled: passthrough, back-to-back samples across the boundary
    do_reset();
    en_fusion = 0;
    for (int i = 0; i < 8; i++) begin
      IR_vld = 1; lft_IR = 12'hA70; rght_IR = 12'h970;
      dsrd_hdng = 12'($urandom_range(0, 4095));
      tick();
    end
    IR_vld = 0;
    for (int i = 0; i < 3; i++) begin
      dsrd_hdng = 12'($urandom_range(0, 4095));
      tick();
    end
    en_fusion = 1; dsrd_hdng = 12'h200;
    tick();
    check("reen_adj", 32'($unsigned(dsrd_hdng_adj)), 32'h202);
    check("reen_vld", 32'(adj_vld), 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      IR_vld   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        lft_IR  = 12'($urandom_range(0, 4095));
        rght_IR = 12'($urandom_range(0, 4095));
      end else begin
        lft_IR  = 12'($urandom_range(12'h8C0, 12'hA40));
        rght_IR = 12'($urandom_range(12'h8C0, 12'hA40));
      end
      lft_opn  = ($urandom_range(0, 9) == 0);
      rght_opn = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) en_fusion = ~en_fusion;
      if ($urandom_range(0, 3) == 0)
        dsrd_hdng = ($urandom_range(0, 1) != 0) ? 12'($urandom_range(12'h7C0, 12'h7FF))
                                                : 12'($urandom_range(12'h800, 12'h840));
      else
        dsrd_hdng = 12'($urandom_range(0, 4095));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_fusion_pipe.md
# ir_fusion_pipe

Sequential, parametrised successor to the combinational IR heading-fusion stage. It sits between the IR sensor front end and the heading controller. It averages left/right IR readings over a power-of-two sample window and computes the centring error internally, replacing the external IR derivative input with an internally generated derivative term. The resulting correction is registered, added to the desired heading with saturation, and delivered with a valid strobe.

## Interface
- `W`, 12: IR sample and heading width (bits).
- `NOM_IR`, 12'h970: nominal IR reading when centred (`W` bits).
- `AVG_LOG2`, 2: log2 of samples per averaging window (window = 4).
- `P_SHFT`, 5: proportional term arithmetic right shift.
- `D_SHFT`, 2: derivative term arithmetic right shift.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `IR_vld` in 1: one-cycle strobe marking a new sample pair.
- `lft_IR`, `rght_IR` in `W`: unsigned IR readings, sampled on `IR_vld`.
- `lft_opn`, `rght_opn` in 1: side-open flags, sampled on `IR_vld`.
- `en_fusion` in 1: apply IR correction when high.
- `dsrd_hdng` in `W` signed: desired heading.
- `dsrd_hdng_adj` out `W` signed: registered adjusted heading.
- `adj_vld` out 1: one-cycle pulse when `dsrd_hdng_adj` first reflects a new correction.
- `sat` out 1: registered with `dsrd_hdng_adj`; high when the sum was clamped.

## Operation
- FSM states are `ACCUM` and `COMPUTE`. Reset state is `ACCUM`.
- **`ACCUM`:**
  - Each `IR_vld` adds `lft_IR`/`rght_IR` into `W+AVG_LOG2`-bit accumulators and increments the sample count.
  - Each `IR_vld` also ORs `lft_opn`/`rght_opn` into window-sticky open flags.
  - When the 2^`AVG_LOG2`-th sample is captured, the FSM goes to `COMPUTE`.
- **`COMPUTE`** (exactly one cycle):
  - Averages are `acc >> AVG_LOG2`.
  - Error `err` is `W+1` bits signed:
    - both open: 0.
    - left open: `NOM_IR - rght_avg`.
    - right open only: `lft_avg - NOM_IR`.
    - both closed: `(lft_avg - rght_avg) >>> 1`.
  - `P = err >>> P_SHFT`.
  - `D = (err - err_prev) >>> D_SHFT`, computed at `W+2` bits.
  - `corr = (P + D) >>> 1`, registered.
  - `err_prev <= err`. When both sides are open, `err_prev <= 0`.
  - Accumulators, count and open flags clear.
  - An `IR_vld` arriving in `COMPUTE` loads as the first sample of the next window (count = 1), not lost.
  - FSM returns to `ACCUM`.
- **Output register** (every cycle):
  - `en_fusion` = 1: `dsrd_hdng_adj <= clamp(dsrd_hdng + corr)`, computed at `W+1` bits and clamped to [-2^(W-1), 2^(W-1)-1]. `sat` is high when clamped.
  - `en_fusion` = 0: `dsrd_hdng_adj <= dsrd_hdng` and `sat <= 0`.
  - `corr` and `err_prev` keep updating regardless of `en_fusion`.
- `adj_vld` pulses one cycle after `corr` updates, only when `en_fusion` is high.
- Reset values: `dsrd_hdng_adj` = 0, `sat` = 0, `adj_vld` = 0, `corr` = 0, `err_prev` = 0, accumulators and count = 0.

## Timing
- Edge E0 captures the last sample of the window.
- The cycle after E0 is `COMPUTE`; edge E1 registers `corr`.
- Edge E2 registers `dsrd_hdng_adj` with the new `corr`, and `adj_vld` is high for that cycle. Window latency is therefore 2 clocks.
- Heading passthrough latency is 1 clock in both modes.
- Reset mid-window discards the partial window. The first valid correction needs a full new window.
- `IR_vld` on consecutive cycles is legal, including across a window boundary.
- `en_fusion` toggles take effect on the next edge. There is no glitch or hold of the stale value.

## Structure
- Package `ir_fusion_pkg` holds:
  - the state enum `ir_fsm_t {ACCUM, COMPUTE}`;
  - the default `NOM_IR`;
  - a `sat_add` function (`W+1` to `W` clamp).
- Sub-module `ir_window_avg` is instantiated per side. It contains the accumulator, the sticky open flag, and a clear/load control. Count and FSM live in the top.

## Test plan
Values below use the default parameters.
1. **Reset:** assert `rst` mid-window. Outputs go to 0, and state is `ACCUM` with count 0. The first `adj_vld` comes only 2 clocks after 4 further samples.
2. **Both closed, two windows:**
   - Stimulus: `lft` = 0xA70, `rght` = 0x970, `dsrd_hdng` = 0x100, `en_fusion` = 1.
   - Window 1: `err` = 128, `P` = 4, `D` = 32, `corr` = 18, so `dsrd_hdng_adj` = 0x112.
   - Window 2: `D` = 0, `corr` = 2, so `dsrd_hdng_adj` = 0x102.
3. **Right open for one sample:**
   - Stimulus: `rght_opn` high on one sample, `lft` = 0x9F0.
   - Required: `err` = 128 from `lft_avg - NOM`, so `dsrd_hdng_adj` = 0x112.
4. **Both open:**
   - Required: `corr` = 0 and `dsrd_hdng_adj` = `dsrd_hdng`.
   - Required: `err_prev` is 0, so a following closed window with `err` = 128 again gives `corr` = 18.
5. **Saturation:**
   - Stimulus: `dsrd_hdng` = 0x7F0 with `corr` = 18.
   - Required: `dsrd_hdng_adj` = 0x7FF and `sat` = 1.
   - Negative mirror: result 0x800 and `sat` = 1.
6. **`en_fusion` low:**
   - Required: `dsrd_hdng_adj` tracks `dsrd_hdng` with a 1-cycle lag, and `adj_vld` stays 0.
   - `IR_vld` on back-to-back cycles across the boundary: no sample is dropped.
   - Re-enabling uses the up-to-date `corr`.
